// File: rtl/bp_cce_deserializer_pkg.sv
// BedRock memory message types shared by the CCE deserializer and its bench.
// Provides the message-type and size enums, the common header layout, the
// wide (64b data) CCE and narrow (32b data) split message structs, their
// flattened widths, and a helper that rewrites a header's size and address.
package bp_cce_deserializer_pkg;

  localparam int paddr_width_p   = 40;
  localparam int lce_id_width_p  = 8;
  localparam int lce_assoc_p     = 8;
  localparam int way_id_width_lp = $clog2(lce_assoc_p);
  localparam int word_width_gp   = 32;
  localparam int dword_width_gp  = 64;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]  lce_id;
    logic [way_id_width_lp-1:0] way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s    payload;
    bp_bedrock_msg_size_e       size;
    logic [paddr_width_p-1:0]   addr;
    bp_bedrock_mem_type_e       msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    bp_bedrock_mem_header_s     header;
    logic [dword_width_gp-1:0]  data;
  } bp_bedrock_cce_mem_msg_s;

  typedef struct packed {
    bp_bedrock_mem_header_s     header;
    logic [word_width_gp-1:0]   data;
  } bp_bedrock_split_mem_msg_s;

  localparam int cce_mem_msg_width_lp   = $bits(bp_bedrock_cce_mem_msg_s);
  localparam int split_mem_msg_width_lp = $bits(bp_bedrock_split_mem_msg_s);

  // Copy of a header with size and address replaced; everything else passes.
  function automatic bp_bedrock_mem_header_s header_resize(
    input bp_bedrock_mem_header_s   h,
    input bp_bedrock_msg_size_e     size,
    input logic [paddr_width_p-1:0] addr
  );
    bp_bedrock_mem_header_s r;
    r      = h;
    r.size = size;
    r.addr = addr;
    return r;
  endfunction

endpackage

// File: rtl/bp_cce_deserializer_gather.sv
// Beat0 holding register for the command deserializer.
// Captures the header and 32b data of the first narrow beat of a pair and
// holds them until the partner beat arrives.
// Ports: clk_i, en_i (capture strobe), header_i/data_i (narrow beat),
//        header_o/data_o (held beat0).
module bp_cce_deserializer_gather
  import bp_cce_deserializer_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       en_i,
  input  bp_bedrock_mem_header_s     header_i,
  input  logic [word_width_gp-1:0]   data_i,
  output bp_bedrock_mem_header_s     header_o,
  output logic [word_width_gp-1:0]   data_o
);

  // No reset: contents are only consulted while the FSM says beat0 is valid.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      header_o <= header_i;
      data_o   <= data_i;
    end
  end

endmodule

// File: rtl/bp_cce_deserializer.sv
// Narrow-to-wide BedRock memory bridge.
// Command path: merges two 32b size_4 commands (A, A+4) into one 64b size_8
// command; the wide command is presented combinationally while beat1 is on
// the input, so pairs stream back to back with no bubbles.
// Response path: splits each 64b response into two 32b responses, low word
// first; the wide response is dequeued once its high half is consumed.
// protocol_error_o is a sticky flag for malformed pairs; data still flows.
// Ports: clk_i/reset_i (sync, active high); io_cmd_* narrow in / wide out
// (ready-and); io_resp_* wide in / narrow out (valid-yumi); protocol_error_o.
module bp_cce_deserializer
  import bp_cce_deserializer_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [split_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                              io_cmd_v_i,
  output logic                              io_cmd_ready_o,

  output logic [cce_mem_msg_width_lp-1:0]   io_cmd_o,
  output logic                              io_cmd_v_o,
  input  logic                              io_cmd_ready_i,

  input  logic [cce_mem_msg_width_lp-1:0]   io_resp_i,
  input  logic                              io_resp_v_i,
  output logic                              io_resp_yumi_o,

  output logic [split_mem_msg_width_lp-1:0] io_resp_o,
  output logic                              io_resp_v_o,
  input  logic                              io_resp_yumi_i,

  output logic                              protocol_error_o
);

  typedef enum logic {e_low, e_high} cmd_state_e;

  bp_bedrock_split_mem_msg_s cmd_in, resp_out;
  bp_bedrock_cce_mem_msg_s   cmd_out, resp_in;

  assign cmd_in    = io_cmd_i;
  assign resp_in   = io_resp_i;
  assign io_cmd_o  = cmd_out;
  assign io_resp_o = resp_out;

  // ---------------- command path ----------------
  cmd_state_e                 state_r;
  bp_bedrock_mem_header_s     beat0_header;
  logic [word_width_gp-1:0]   beat0_data;
  logic                       beat0_accept, beat1_accept;
  logic                       beat0_bad, beat1_bad;
  logic                       protocol_error_r;

  assign beat0_accept = (state_r == e_low)  & io_cmd_v_i;
  assign beat1_accept = (state_r == e_high) & io_cmd_v_i & io_cmd_ready_i;

  bp_cce_deserializer_gather gather (
    .clk_i    (clk_i),
    .en_i     (beat0_accept),
    .header_i (cmd_in.header),
    .data_i   (cmd_in.data),
    .header_o (beat0_header),
    .data_o   (beat0_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_low;
    end else begin
      case (state_r)
        e_low:   if (io_cmd_v_i) state_r <= e_high;
        e_high:  if (io_cmd_v_i & io_cmd_ready_i) state_r <= e_low;
        default: state_r <= e_low;
      endcase
    end
  end

  // Beat0 always fits in the holding register, so the input is only
  // backpressured while beat1 waits on the wide side.
  assign io_cmd_ready_o = (state_r == e_low) | io_cmd_ready_i;
  assign io_cmd_v_o     = (state_r == e_high) & io_cmd_v_i;

  assign cmd_out.header = header_resize(beat0_header, e_bedrock_msg_size_8,
                                        beat0_header.addr);
  assign cmd_out.data   = {cmd_in.data, beat0_data};

  // Pairing check: observational only, the merge proceeds regardless.
  assign beat0_bad = (cmd_in.header.size != e_bedrock_msg_size_4)
                   | (cmd_in.header.addr[2:0] != 3'b000);
  assign beat1_bad = (cmd_in.header.addr != beat0_header.addr + paddr_width_p'(4))
                   | (cmd_in.header.msg_type != beat0_header.msg_type)
                   | (cmd_in.header.size != e_bedrock_msg_size_4);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      protocol_error_r <= 1'b0;
    else if ((beat0_accept & beat0_bad) | (beat1_accept & beat1_bad))
      protocol_error_r <= 1'b1;
  end

  assign protocol_error_o = protocol_error_r;

  // ---------------- response path ----------------
  // toggle_r selects which half of the current wide response is presented.
  logic toggle_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      toggle_r <= 1'b0;
    else if (io_resp_yumi_i)
      toggle_r <= ~toggle_r;
  end

  assign io_resp_v_o     = io_resp_v_i;
  assign io_resp_yumi_o  = io_resp_yumi_i & toggle_r;
  assign resp_out.header = header_resize(resp_in.header, e_bedrock_msg_size_4,
                             resp_in.header.addr
                             + (toggle_r ? paddr_width_p'(4) : paddr_width_p'(0)));
  assign resp_out.data   = toggle_r ? resp_in.data[63:32] : resp_in.data[31:0];

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i)
                   io_resp_yumi_i |-> io_resp_v_i)
    else $error("narrow response consumed while no wide response valid");

  assert property (@(posedge clk_i) disable iff (reset_i)
                   io_resp_v_i |-> (resp_in.header.size == e_bedrock_msg_size_8))
    else $error("wide response size is not 8 bytes");
`endif

endmodule
